// File: rtl/register_file_mp.sv
// rtl/register_file_mp.sv - multi-port scalar regfile with flags, scoreboard and double-buffered vertex bank
module register_file_mp #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 5,
  parameter int NUM_RD    = 2,
  parameter int NUM_VREG  = 8,
  parameter int FLAG_ADDR = 30,
  parameter int ZERO_R0   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
  output logic [NUM_RD*DATA_W-1:0]      rd_data,
  input  logic                          we0,
  input  logic [ADDR_W-1:0]             wr_addr0,
  input  logic [DATA_W-1:0]             wr_data0,
  input  logic                          we1,
  input  logic [ADDR_W-1:0]             wr_addr1,
  input  logic [DATA_W-1:0]             wr_data1,
  input  logic                          flags_we,
  input  logic [DATA_W-1:0]             flags_in,
  output logic [DATA_W-1:0]             flags_out,
  input  logic                          sb_set,
  input  logic [ADDR_W-1:0]             sb_addr,
  output logic [(1<<ADDR_W)-1:0]        sb_busy,
  input  logic                          vpu_valid,
  output logic                          vpu_ready,
  input  logic [NUM_VREG*DATA_W-1:0]    vpu_v,
  input  logic [DATA_W-1:0]             vpu_ro,
  input  logic                          swap_req,
  output logic                          swap_ack,
  output logic [NUM_VREG*DATA_W-1:0]    read_v,
  output logic [DATA_W-1:0]             read_ro
);

  localparam int NUM_REGS = 1 << ADDR_W;
  localparam int VW       = NUM_VREG * DATA_W;
  localparam logic [ADDR_W-1:0] FLAG_A = ADDR_W'(FLAG_ADDR);
  // Bit 0 cleared when R0 is hardwired, so R0 is never written nor marked busy.
  localparam logic [NUM_REGS-1:0] WR_MASK = {{(NUM_REGS-1){1'b1}}, (ZERO_R0 == 0)};

  // ---------------------------------------------------------------- scalar file
  logic [NUM_REGS*DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]        sel0, sel1, self, sels;

  always_comb begin
    sel0 = '0;
    sel1 = '0;
    self = '0;
    sels = '0;
    sel0[wr_addr0] = we0;
    sel1[wr_addr1] = we1;
    self[FLAG_A]   = flags_we;
    sels[sb_addr]  = sb_set;
    sel0 = sel0 & WR_MASK;
    sel1 = sel1 & WR_MASK;
    self = self & WR_MASK;
    sels = sels & WR_MASK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (sel1[i])
          regs[i*DATA_W +: DATA_W] <= wr_data1;
        else if (sel0[i])
          regs[i*DATA_W +: DATA_W] <= wr_data0;
        else if (self[i])
          regs[i*DATA_W +: DATA_W] <= flags_in;
      end
    end
  end

  assign flags_out = regs[FLAG_A*DATA_W +: DATA_W];

  // Read ports: later assignments override earlier ones, giving we1 > we0 > flags_we.
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = rd_addr[k*ADDR_W +: ADDR_W];

    always_comb begin
      data = regs[addr*DATA_W +: DATA_W];
      if (flags_we && addr == FLAG_A)
        data = flags_in;
      if (we0 && addr == wr_addr0)
        data = wr_data0;
      if (we1 && addr == wr_addr1)
        data = wr_data1;
      if (ZERO_R0 != 0 && addr == '0)
        data = '0;
    end

    assign rd_data[k*DATA_W +: DATA_W] = data;
  end

  // ---------------------------------------------------------------- scoreboard
  // A set on the same register as a clearing write wins because it is OR-ed last.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sb_busy <= '0;
    else
      sb_busy <= ((sb_busy & ~(sel0 | sel1)) | sels) & WR_MASK;
  end

  // ---------------------------------------------------------------- vertex banks
  typedef enum logic {V_EMPTY = 1'b0, V_FULL = 1'b1} vstate_t;

  vstate_t           state, state_nxt;
  logic              bank_sel;
  logic [VW-1:0]     bank_v  [2];
  logic [DATA_W-1:0] bank_ro [2];
  logic              accept, do_swap;

  assign accept  = (state == V_EMPTY) && vpu_valid;
  assign do_swap = (state == V_FULL) && swap_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= V_EMPTY;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      V_EMPTY: if (vpu_valid) state_nxt = V_FULL;
      V_FULL:  if (swap_req)  state_nxt = V_EMPTY;
      default: state_nxt = V_EMPTY;
    endcase
  end

  always_comb begin
    vpu_ready = (state == V_EMPTY);
  end

  // The shadow bank is always the one not selected for reading.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_sel   <= 1'b0;
      swap_ack   <= 1'b0;
      bank_v[0]  <= '0;
      bank_v[1]  <= '0;
      bank_ro[0] <= '0;
      bank_ro[1] <= '0;
    end else begin
      swap_ack <= do_swap;
      if (do_swap)
        bank_sel <= ~bank_sel;
      if (accept) begin
        bank_v[~bank_sel]  <= vpu_v;
        bank_ro[~bank_sel] <= vpu_ro;
      end
    end
  end

  assign read_v  = bank_v[bank_sel];
  assign read_ro = bank_ro[bank_sel];

endmodule
